// File: rtl/rv32i_encoder_if.sv
// Request/response bundle of the RV32I instruction encoder.
// The encoder sits on the slave side; the loader or stimulus source drives the master side.
interface rv32i_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [4:0]  in_rd;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        err_valid;
  logic [2:0]  err_code;
  logic        err_sticky;
  logic [15:0] out_count;

  modport slave (
    input  in_valid, in_opcode, in_funct3, in_funct7, in_rs1, in_rs2, in_rd, in_imm,
    input  out_ready,
    output in_ready, out_valid, out_instr, err_valid, err_code, err_sticky, out_count
  );

  modport master (
    output in_valid, in_opcode, in_funct3, in_funct7, in_rs1, in_rs2, in_rd, in_imm,
    output out_ready,
    input  in_ready, out_valid, out_instr, err_valid, err_code, err_sticky, out_count
  );
endinterface

// File: rtl/rv32i_encoder.sv
// Streaming RV32I encoder: packs field-level requests into instruction words,
// range-checks the immediate and buffers results in a 2-entry output queue.
module rv32i_encoder (
  input  logic            clk,
  input  logic            rst_n,
  rv32i_encoder_if.slave  bus
);
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_CSR   = 7'b1110011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_BAD_OP   = 3'd1;
  localparam logic [2:0] ERR_RANGE    = 3'd2;
  localparam logic [2:0] ERR_MISALIGN = 3'd3;

  logic [6:0]  op;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm;
  logic        is_shift, i_ok, b_ok, j_ok;
  logic [31:0] word;
  logic [2:0]  code;

  logic [1:0]  count;
  logic [31:0] head, tail;
  logic        accept, push, pop;
  logic        err_valid_q, err_sticky_q;
  logic [2:0]  err_code_q;
  logic [15:0] out_count_q;

  assign op  = bus.in_opcode;
  assign f3  = bus.in_funct3;
  assign f7  = bus.in_funct7;
  assign rs1 = bus.in_rs1;
  assign rs2 = bus.in_rs2;
  assign rd  = bus.in_rd;
  assign imm = bus.in_imm;

  // Shift-immediates are op_imm with funct3 001 (sll) or 101 (srl/sra).
  assign is_shift = (op == OP_IMM) && (f3[1:0] == 2'b01);
  assign i_ok     = (&imm[31:11]) | (~|imm[31:11]);
  assign b_ok     = (&imm[31:12]) | (~|imm[31:12]);
  assign j_ok     = (&imm[31:20]) | (~|imm[31:20]);

  always_comb begin
    word = '0;
    code = ERR_NONE;
    case (op)
      OP_REG: word = {f7, rs2, rs1, f3, rd, op};
      OP_IMM, OP_LOAD, OP_JALR, OP_CSR: begin
        if (is_shift) begin
          word = {f7, imm[4:0], rs1, f3, rd, op};
          if (|imm[31:5]) code = ERR_RANGE;
        end else begin
          word = {imm[11:0], rs1, f3, rd, op};
          if (!i_ok) code = ERR_RANGE;
        end
      end
      OP_STORE: begin
        word = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
        if (!i_ok) code = ERR_RANGE;
      end
      OP_BR: begin
        word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
        if (imm[0])     code = ERR_MISALIGN;
        else if (!b_ok) code = ERR_RANGE;
      end
      OP_JAL: begin
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        if (imm[0])     code = ERR_MISALIGN;
        else if (!j_ok) code = ERR_RANGE;
      end
      OP_LUI, OP_AUIPC: begin
        word = {imm[31:12], rd, op};
        if (|imm[11:0]) code = ERR_RANGE;
      end
      default: code = ERR_BAD_OP;
    endcase
  end

  // in_ready comes from the registered count only, so out_ready never reaches it.
  assign bus.in_ready = (count != 2'd2);
  assign accept       = bus.in_valid && bus.in_ready;
  assign push         = accept && (code == ERR_NONE);
  assign pop          = (count != 2'd0) && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count        <= 2'd0;
      head         <= '0;
      tail         <= '0;
      err_valid_q  <= 1'b0;
      err_code_q   <= ERR_NONE;
      err_sticky_q <= 1'b0;
      out_count_q  <= '0;
    end else begin
      err_valid_q <= accept && (code != ERR_NONE);
      if (accept && (code != ERR_NONE)) begin
        err_code_q   <= code;
        err_sticky_q <= 1'b1;
      end
      if (pop) out_count_q <= out_count_q + 16'd1;

      // Head is left untouched on the last pop so out_instr keeps the popped word.
      case (count)
        2'd0: if (push) begin
          head  <= word;
          count <= 2'd1;
        end
        2'd1: begin
          if (push && pop) begin
            head <= word;
          end else if (push) begin
            tail  <= word;
            count <= 2'd2;
          end else if (pop) begin
            count <= 2'd0;
          end
        end
        2'd2: if (pop) begin
          head  <= tail;
          count <= 2'd1;
        end
        default: count <= 2'd0;
      endcase
    end
  end

  assign bus.out_valid  = (count != 2'd0);
  assign bus.out_instr  = head;
  assign bus.err_valid  = err_valid_q;
  assign bus.err_code   = err_code_q;
  assign bus.err_sticky = err_sticky_q;
  assign bus.out_count  = out_count_q;
endmodule

// File: tb/tb_rv32i_encoder.sv
// Self-checking bench for rv32i_encoder: fixed vectors, hand sequences for
// backpressure/reset, and random traffic against a queue-based reference model.
module tb_rv32i_encoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rv32i_encoder_if bus ();
  rv32i_encoder dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
  } req_t;

  typedef struct {
    req_t        r;
    logic [31:0] word;
    logic [2:0]  code;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] mq[$];
  logic [31:0] m_last = '0;
  logic        m_errv = 1'b0;
  logic [2:0]  m_code = '0;
  logic        m_sticky = 1'b0;
  logic [15:0] m_cnt = '0;

  function automatic req_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic [31:0] imm);
    req_t r;
    r.op = op; r.f3 = f3; r.f7 = f7; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.imm = imm;
    return r;
  endfunction

  // Reference: numeric immediate ranges and shift/mask bit placement.
  function automatic void ref_enc(input req_t r, output logic [31:0] w, output int code);
    int          si;
    logic [31:0] base;
    si   = $signed(r.imm);
    base = (32'(r.rs1) << 15) | (32'(r.f3) << 12) | 32'(r.op);
    w    = '0;
    code = 0;
    case (r.op)
      7'h33: w = (32'(r.f7) << 25) | (32'(r.rs2) << 20) | base | (32'(r.rd) << 7);
      7'h13, 7'h03, 7'h67, 7'h73: begin
        if (r.op == 7'h13 && (r.f3 == 3'd1 || r.f3 == 3'd5)) begin
          if (r.imm > 32'd31) code = 2;
          w = (32'(r.f7) << 25) | ((r.imm & 32'h1F) << 20) | base | (32'(r.rd) << 7);
        end else begin
          if (si < -2048 || si > 2047) code = 2;
          w = ((r.imm & 32'hFFF) << 20) | base | (32'(r.rd) << 7);
        end
      end
      7'h23: begin
        if (si < -2048 || si > 2047) code = 2;
        w = (((r.imm >> 5) & 32'h7F) << 25) | (32'(r.rs2) << 20) | base | ((r.imm & 32'h1F) << 7);
      end
      7'h63: begin
        if (r.imm[0]) code = 3;
        else if (si < -4096 || si > 4095) code = 2;
        w = (((r.imm >> 12) & 32'h1) << 31) | (((r.imm >> 5) & 32'h3F) << 25) | (32'(r.rs2) << 20)
          | base | (((r.imm >> 1) & 32'hF) << 8) | (((r.imm >> 11) & 32'h1) << 7);
      end
      7'h6F: begin
        if (r.imm[0]) code = 3;
        else if (si < -1048576 || si > 1048575) code = 2;
        w = (((r.imm >> 20) & 32'h1) << 31) | (((r.imm >> 1) & 32'h3FF) << 21)
          | (((r.imm >> 11) & 32'h1) << 20) | (((r.imm >> 12) & 32'hFF) << 12)
          | (32'(r.rd) << 7) | 32'(r.op);
      end
      7'h37, 7'h17: begin
        if ((r.imm % 32'd4096) != 32'd0) code = 2;
        w = (r.imm & 32'hFFFFF000) | (32'(r.rd) << 7) | 32'(r.op);
      end
      default: code = 1;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, compare against model, advance model, wait posedge.
  task automatic cycle(input logic v, input req_t r, input logic ordy);
    logic [31:0] w;
    int          code;
    logic        acc, pop;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_opcode = r.op;  bus.in_funct3 = r.f3; bus.in_funct7 = r.f7;
    bus.in_rs1    = r.rs1; bus.in_rs2    = r.rs2; bus.in_rd    = r.rd;
    bus.in_imm    = r.imm;
    bus.out_ready = ordy;
    chk("in_ready",   32'(bus.in_ready),   32'(mq.size() < 2));
    chk("out_valid",  32'(bus.out_valid),  32'(mq.size() > 0));
    chk("out_instr",  bus.out_instr,       (mq.size() > 0) ? mq[0] : m_last);
    chk("err_valid",  32'(bus.err_valid),  32'(m_errv));
    chk("err_code",   32'(bus.err_code),   32'(m_code));
    chk("err_sticky", 32'(bus.err_sticky), 32'(m_sticky));
    chk("out_count",  32'(bus.out_count),  32'(m_cnt));
    ref_enc(r, w, code);
    acc = v && (mq.size() < 2);
    pop = (mq.size() > 0) && ordy;
    if (pop) begin
      m_last = mq.pop_front();
      m_cnt++;
    end
    if (acc && code == 0) mq.push_back(w);
    m_errv = acc && (code != 0);
    if (m_errv) begin
      m_code   = 3'(code);
      m_sticky = 1'b1;
    end
    @(posedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"},   32'(bus.in_ready),   32'd1);
    chk({tag, "_out_valid"},  32'(bus.out_valid),  32'd0);
    chk({tag, "_out_instr"},  bus.out_instr,       32'd0);
    chk({tag, "_err_valid"},  32'(bus.err_valid),  32'd0);
    chk({tag, "_err_code"},   32'(bus.err_code),   32'd0);
    chk({tag, "_err_sticky"}, 32'(bus.err_sticky), 32'd0);
    chk({tag, "_out_count"},  32'(bus.out_count),  32'd0);
  endtask

  function automatic req_t rand_req();
    logic [6:0] ops[12];
    req_t       r;
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F, 7'h00};
    r.op  = ops[$urandom_range(0, 11)];
    r.f3  = 3'($urandom_range(0, 7));
    r.f7  = 7'($urandom_range(0, 127));
    r.rs1 = 5'($urandom_range(0, 31));
    r.rs2 = 5'($urandom_range(0, 31));
    r.rd  = 5'($urandom_range(0, 31));
    case ($urandom_range(0, 3))
      0: r.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
      1: r.imm = $urandom;
      2: r.imm = $urandom & 32'hFFFFF000;
      default: r.imm = 32'($urandom_range(0, 40));
    endcase
    return r;
  endfunction

  vec_t tv[16];
  req_t idle;
  req_t addi5;
  int   n_ok;

  initial begin
    idle  = mk(7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    addi5 = mk(7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5);
    tv[0]  = '{addi5,                                                      32'h00500093, 3'd0};
    tv[1]  = '{mk(7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'd0),            32'h002081B3, 3'd0};
    tv[2]  = '{mk(7'h23, 3'd2, 7'h00, 5'd1, 5'd2, 5'd0, 32'd8),            32'h0020A423, 3'd0};
    tv[3]  = '{mk(7'h37, 3'd0, 7'h00, 5'd0, 5'd0, 5'd5, 32'h12345000),     32'h123452B7, 3'd0};
    tv[4]  = '{mk(7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC),     32'hFE000EE3, 3'd0};
    tv[5]  = '{mk(7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'h00000800),     32'h001000EF, 3'd0};
    tv[6]  = '{mk(7'h13, 3'd1, 7'h00, 5'd2, 5'd0, 5'd1, 32'd3),            32'h00311093, 3'd0};
    tv[7]  = '{mk(7'h13, 3'd5, 7'h20, 5'd2, 5'd0, 5'd1, 32'd3),            32'h40315093, 3'd0};
    tv[8]  = '{mk(7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'd2048),         32'h0,        3'd2};
    tv[9]  = '{mk(7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd3),            32'h0,        3'd3};
    tv[10] = '{mk(7'h7F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd0),            32'h0,        3'd1};
    tv[11] = '{mk(7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h00010001),     32'h0,        3'd3};
    tv[12] = '{mk(7'h37, 3'd0, 7'h00, 5'd0, 5'd0, 5'd5, 32'h00000001),     32'h0,        3'd2};
    tv[13] = '{mk(7'h13, 3'd1, 7'h00, 5'd2, 5'd0, 5'd1, 32'd32),           32'h0,        3'd2};
    tv[14] = '{mk(7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFF00000),     32'h8000006F, 3'd0};
    tv[15] = '{mk(7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'hFFFFF800),     32'h80000093, 3'd0};

    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_opcode = '0; bus.in_funct3 = '0; bus.in_funct7 = '0;
    bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_rd = '0; bus.in_imm = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors, out_ready held high.
    n_ok = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, tv[i].r, 1'b1);
      #1;
      if (tv[i].code == 3'd0) begin
        n_ok++;
        chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'd1);
        chk($sformatf("vec%0d_word", i),  bus.out_instr,      tv[i].word);
      end else begin
        chk($sformatf("vec%0d_errv", i), 32'(bus.err_valid), 32'd1);
        chk($sformatf("vec%0d_code", i), 32'(bus.err_code),  32'(tv[i].code));
      end
    end
    cycle(1'b0, idle, 1'b1);
    #1;
    chk("table_out_count", 32'(bus.out_count), 32'(n_ok));

    // Backpressure: two accepted, third stalls until a pop frees a slot.
    cycle(1'b1, mk(7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd11), 1'b0);
    cycle(1'b1, mk(7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd2, 32'd22), 1'b0);
    cycle(1'b1, mk(7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd3, 32'd33), 1'b0);
    #1;
    chk("bp_full_in_ready", 32'(bus.in_ready), 32'd0);
    cycle(1'b1, mk(7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd3, 32'd33), 1'b1);
    cycle(1'b1, mk(7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd3, 32'd33), 1'b1);
    repeat (3) cycle(1'b0, idle, 1'b1);

    // Simultaneous push and pop with one word queued.
    cycle(1'b1, mk(7'h33, 3'd0, 7'h20, 5'd4, 5'd5, 5'd6, 32'd0), 1'b0);
    cycle(1'b1, mk(7'h23, 3'd2, 7'd0, 5'd7, 5'd8, 5'd0, 32'hFFFFFFF0), 1'b1);
    cycle(1'b0, idle, 1'b0);
    repeat (2) cycle(1'b0, idle, 1'b1);

    // Reset with two words queued and an error recorded.
    cycle(1'b1, mk(7'h7F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0), 1'b0);
    cycle(1'b1, addi5, 1'b0);
    cycle(1'b1, mk(7'h37, 3'd0, 7'd0, 5'd0, 5'd0, 5'd9, 32'hABCDE000), 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    mq.delete();
    m_last = '0; m_errv = 1'b0; m_code = '0; m_sticky = 1'b0; m_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, addi5, 1'b1);
    #1;
    chk("post_rst_word", bus.out_instr, 32'h00500093);
    cycle(1'b0, idle, 1'b1);

    // Random traffic against the reference model.
    for (int i = 0; i < 600; i++)
      cycle(($urandom_range(0, 9) < 7), rand_req(), ($urandom_range(0, 9) < 6));
    repeat (4) cycle(1'b0, idle, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rv32i_encoder.md
# rv32i_encoder

Streaming RV32I instruction encoder: the inverse of the instruction decoder. Accepts field-level requests (opcode, funct3, funct7, register indices, full 32-bit immediate) on a valid/ready port. Packs each request into a 32-bit instruction word and range-checks the immediate. Buffers words in a 2-entry output queue for the instruction-memory loader and self-test stimulus generator.

## Interface
- No parameters; all widths fixed by RV32I.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  encoder can accept; equals (queue count != 2).
- in_opcode  in  7  rv32i_opcode value.
- in_funct3  in  3  funct3 field.
- in_funct7  in  7  funct7 field; used by R-type and shift-immediate only.
- in_rs1, in_rs2, in_rd  in  5 each  register indices.
- in_imm  in  32  immediate as the decoder would produce it (sign-extended, byte offset).
- out_valid  out  1  queue head holds a word.
- out_ready  in  1  consumer takes head.
- out_instr  out  32  encoded word at queue head.
- err_valid  out  1  one-cycle pulse: a request was rejected.
- err_code  out  3  0 none, 1 bad opcode, 2 imm range, 3 imm misaligned; held until next error.
- err_sticky  out  1  set on any error, cleared only by reset.
- out_count  out  16  words popped from the output, wraps at 0xFFFF→0.

## Operation
- Format is selected by opcode:
  - R: op_reg (0110011).
  - I: op_imm, op_load, op_jalr, op_csr.
  - S: op_store.
  - B: op_br.
  - U: op_lui, op_auipc.
  - J: op_jal.
- Any other opcode → error 1.
- Packing:
  - R: {funct7, rs2, rs1, funct3, rd, op}.
  - I: {imm[11:0], rs1, funct3, rd, op}.
  - I shift (op_imm with funct3 001/101): {funct7, imm[4:0], rs1, funct3, rd, op}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}.
  - U: {imm[31:12], rd, op}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
- Unused fields are ignored. R-type ignores imm.
- Immediate checks:
  - I/S: imm[31:11] all equal.
  - Shift: imm[31:5]==0.
  - B: imm[31:12] all equal and imm[0]==0.
  - J: imm[31:20] all equal and imm[0]==0.
  - U: imm[11:0]==0.
- Error priority: bad opcode > misaligned (B/J imm[0]) > range. U low bits nonzero counts as range.
- A request with an error is consumed (handshake completes) but is not pushed. err_valid pulses, err_code updates, err_sticky sets.
- Queue: 2-entry FIFO, head drives out_instr. Push occurs on in_valid & in_ready & no error. Pop occurs on out_valid & out_ready.
- Push and pop in the same cycle: count unchanged, order preserved.
- in_ready does not depend on out_ready (no combinational path). When full, in_ready is low even if out_ready is high that cycle.
- out_count increments on each pop and wraps modulo 2^16.

## Timing
- Reset (async assert, sync-safe deassert):
  - queue empty, out_valid=0, out_instr=0, in_ready=1.
  - err_valid=0, err_code=0, err_sticky=0, out_count=0.
- Latency: request accepted at edge N appears with out_valid=1 in the cycle after N. Encoding and checks are combinational before the queue write.
- err_valid is registered: high for exactly the one cycle after the accepting edge.
- Throughput: 1 word/cycle sustained with out_ready held high.
- With out_ready low, 2 words are accepted, then in_ready drops the cycle after the second accept.
- out_instr is stable while out_valid=1 and out_ready=0. When the queue is empty, out_instr holds the last popped value.
- Reset asserted mid-stream: queue contents discarded immediately, outputs to reset values asynchronously. No partial word is emitted after deassert.

## Test plan
- Basic formats, one per request, out_ready=1:
  - addi x1,x0,5 → 0x00500093.
  - add x3,x1,x2 → 0x002081B3.
  - sw x2,8(x1) → 0x0020A423.
  - lui x5,0x12345000 → 0x123452B7.
  - Each word appears 1 cycle after accept; out_count=4.
- Branch/jump packing:
  - beq x0,x0,imm=-4 → 0xFE000EE3.
  - jal x1,imm=2048 → 0x001000EF.
- Errors:
  - addi imm=2048 → no push, err_valid pulse, err_code=2.
  - beq imm=6... imm=3 → err_code=3.
  - opcode 0x7F → err_code=1.
  - err_sticky=1 after the first error; out_valid stays 0 throughout.
- Backpressure:
  - out_ready=0, three addi requests → first two accepted, in_ready=0 for the third.
  - Then raise out_ready → third is accepted the cycle after the first pop; FIFO order preserved.
- Simultaneous push/pop: queue count=1, push and pop in the same cycle → count stays 1, next word correct.
- Reset mid-operation: rst_n low with 2 words queued and err_sticky=1 → all outputs at reset values the same cycle; after release, a new request encodes normally.
